// File: rtl/fb_rect_writer_pkg.sv
// Shared frame-buffer constants and the rectangle writer FSM encoding.
// The address and palette widths are also used by the VGA display read path.
package fb_rect_writer_pkg;

  localparam int VIDEO_WIDTH   = 640;
  localparam int VIDEO_HEIGHT  = 480;
  localparam int FB_ADDR_WIDTH = $clog2(VIDEO_WIDTH * VIDEO_HEIGHT) + 1;
  localparam int PALETTE_WIDTH = $clog2(256) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fb_rect_writer_clip.sv
// Combinational clip of a rectangle command against the screen.
// Produces the exclusive end column/row and an empty flag.
import fb_rect_writer_pkg::*;

module rect_clip #(
  parameter int WIDTH  = VIDEO_WIDTH,
  parameter int HEIGHT = VIDEO_HEIGHT
) (
  input  logic [9:0]  x0,
  input  logic [8:0]  y0,
  input  logic [9:0]  w,
  input  logic [8:0]  h,
  output logic [10:0] xe,
  output logic [10:0] ye,
  output logic        empty
);

  logic [10:0] x_sum;
  logic [10:0] y_sum;

  // 11 bits holds the largest possible sum, so the min() never sees a wrapped value
  always_comb begin
    x_sum = {1'b0, x0} + {1'b0, w};
    y_sum = {2'b0, y0} + {2'b0, h};
    xe    = (x_sum > 11'(WIDTH))  ? 11'(WIDTH)  : x_sum;
    ye    = (y_sum > 11'(HEIGHT)) ? 11'(HEIGHT) : y_sum;
    empty = ({1'b0, x0} >= 11'(WIDTH)) || ({2'b0, y0} >= 11'(HEIGHT)) ||
            (w == 10'd0) || (h == 9'd0);
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Walks a clipped rectangle row-major and drives the frame-buffer RAM write port,
// one pixel per cycle, stalling whenever writeAllow is low.
import fb_rect_writer_pkg::*;

module fb_rect_writer #(
  parameter int WIDTH      = VIDEO_WIDTH,
  parameter int HEIGHT     = VIDEO_HEIGHT,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = PALETTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [9:0]            x0,
  input  logic [8:0]            y0,
  input  logic [9:0]            w,
  input  logic [8:0]            h,
  input  logic [DATA_WIDTH-1:0] color,
  input  logic                  writeAllow,
  output logic                  busy,
  output logic                  done,
  output logic                  wEn,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dataOut
);

  state_t                state_q, state_d;
  logic [9:0]            x0_q, x0_d;
  logic [8:0]            y0_q, y0_d;
  logic [9:0]            w_q, w_d;
  logic [8:0]            h_q, h_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;
  logic [10:0]           xe_q, xe_d;
  logic [10:0]           ye_q, ye_d;
  logic [9:0]            cx_q, cx_d;
  logic [8:0]            cy_q, cy_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;

  logic [10:0] clip_xe;
  logic [10:0] clip_ye;
  logic        clip_empty;
  logic        w_en;
  logic        last_col;
  logic        last_row;

  rect_clip #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_clip (
    .x0   (x0_q),
    .y0   (y0_q),
    .w    (w_q),
    .h    (h_q),
    .xe   (clip_xe),
    .ye   (clip_ye),
    .empty(clip_empty)
  );

  assign w_en     = (state_q == FILL) && writeAllow;
  assign last_col = ({1'b0, cx_q} == (xe_q - 11'd1));
  assign last_row = ({2'b0, cy_q} == (ye_q - 11'd1));

  assign wEn     = w_en;
  assign addr    = row_base_q + ADDR_WIDTH'(cx_q);
  assign dataOut = color_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    xe_d       = xe_q;
    ye_d       = ye_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    row_base_d = row_base_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          w_d     = w;
          h_d     = h;
          color_d = color;
          state_d = CALC;
        end
      end
      // The only multiply: row base is formed once, then stepped by WIDTH per row
      CALC: begin
        xe_d       = clip_xe;
        ye_d       = clip_ye;
        cx_d       = x0_q;
        cy_d       = y0_q;
        row_base_d = ADDR_WIDTH'(y0_q) * ADDR_WIDTH'(WIDTH);
        state_d    = clip_empty ? DONE : FILL;
      end
      FILL: begin
        if (w_en) begin
          if (last_col) begin
            cx_d = x0_q;
            if (last_row) begin
              state_d = DONE;
            end else begin
              cy_d       = cy_q + 9'd1;
              row_base_d = row_base_q + ADDR_WIDTH'(WIDTH);
            end
          end else begin
            cx_d = cx_q + 10'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      xe_q       <= '0;
      ye_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      xe_q       <= xe_d;
      ye_q       <= ye_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      row_base_q <= row_base_d;
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Scoreboard bench for fb_rect_writer: expected writes and done cycles are queued by
// the stimulus and consumed by a negedge monitor.
module tb_fb_rect_writer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  x0;
  logic [8:0]  y0;
  logic [9:0]  w;
  logic [8:0]  h;
  logic [8:0]  color;
  logic        writeAllow;
  logic        busy;
  logic        done;
  logic        wEn;
  logic [19:0] addr;
  logic [8:0]  dataOut;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  int addrQ[$];
  int dataQ[$];
  int doneQ[$];

  fb_rect_writer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .w         (w),
    .h         (h),
    .color     (color),
    .writeAllow(writeAllow),
    .busy      (busy),
    .done      (done),
    .wEn       (wEn),
    .addr      (addr),
    .dataOut   (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  task automatic pushWrite(input int a, input int d);
    addrQ.push_back(a);
    dataQ.push_back(d);
  endtask

  // Monitor: every write and every done pulse must match the head of its queue
  always @(negedge clk) begin
    if (!reset) begin
      if (wEn) begin
        if (addrQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr %0d data %0d expected no write", addr, dataOut);
        end else begin
          checkOutput("write_addr", int'(addr), addrQ.pop_front());
          checkOutput("write_data", int'(dataOut), dataQ.pop_front());
          checkOutput("addr_in_frame", int'(addr < 20'd307200), 1);
        end
      end
      if (done) begin
        if (doneQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done at cycle %0d expected none", cycleCount);
        end else begin
          checkOutput("done_cycle", cycleCount, doneQ.pop_front());
        end
      end
    end
  end

  // Issues one command at cycle 0 and steps through the schedule cycle by cycle
  task automatic applyStimulus(input int ax0, input int ay0, input int aw, input int ah,
                               input int acol, input int doneCyc,
                               input int stallLo, input int stallHi, input int stallAddr,
                               input int startPulseAt, input int resetAt);
    int c0;
    @(posedge clk); #1;
    x0    = 10'(ax0);
    y0    = 9'(ay0);
    w     = 10'(aw);
    h     = 9'(ah);
    color = 9'(acol);
    start = 1'b1;
    writeAllow = 1'b1;
    c0 = cycleCount;
    checkOutput("busy_idle_at_start", int'(busy), 0);
    if (resetAt < 0) doneQ.push_back(c0 + doneCyc);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      start = (k == startPulseAt);
      if (k == startPulseAt) x0 = 10'd300;
      writeAllow = !(k >= stallLo && k <= stallHi);
      if (k == 1) checkOutput("busy_calc", int'(busy), 1);
      if (k >= stallLo && k <= stallHi) begin
        #1;
        checkOutput("stall_wen", int'(wEn), 0);
        checkOutput("stall_addr", int'(addr), stallAddr);
      end
      if (k == resetAt) begin
        reset = 1'b1;
        #1;
        checkOutput("rst_wen", int'(wEn), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_addr", int'(addr), 0);
        checkOutput("rst_data", int'(dataOut), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        break;
      end
      if (resetAt < 0 && k == doneCyc) checkOutput("busy_done", int'(busy), 1);
      if (resetAt < 0 && k == doneCyc + 1) begin
        checkOutput("busy_back_idle", int'(busy), 0);
        break;
      end
    end
    start = 1'b0;
    writeAllow = 1'b1;
    checkOutput("writes_drained", addrQ.size(), 0);
    checkOutput("done_drained", doneQ.size(), 0);
    addrQ.delete();
    dataQ.delete();
    doneQ.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    x0 = '0;
    y0 = '0;
    w = '0;
    h = '0;
    color = '0;
    writeAllow = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_wen", int'(wEn), 0);
    checkOutput("reset_addr", int'(addr), 0);
    checkOutput("reset_data", int'(dataOut), 0);
    reset = 1'b0;

    $display("[TB] basic 3x2 rectangle");
    pushWrite(12810, 5); pushWrite(12811, 5); pushWrite(12812, 5);
    pushWrite(13450, 5); pushWrite(13451, 5); pushWrite(13452, 5);
    applyStimulus(10, 20, 3, 2, 5, 8, -1, -1, 0, -1, -1);

    $display("[TB] bottom-right clip");
    pushWrite(306558, 12); pushWrite(306559, 12);
    pushWrite(307198, 12); pushWrite(307199, 12);
    applyStimulus(638, 478, 5, 5, 12, 6, -1, -1, 0, -1, -1);

    $display("[TB] empty: zero width");
    applyStimulus(5, 5, 0, 3, 7, 2, -1, -1, 0, -1, -1);

    $display("[TB] empty: x0 off screen");
    applyStimulus(700, 5, 4, 3, 7, 2, -1, -1, 0, -1, -1);

    $display("[TB] writeAllow stall in cycles 3-5");
    pushWrite(0, 511); pushWrite(1, 511); pushWrite(640, 511); pushWrite(641, 511);
    applyStimulus(0, 0, 2, 2, 511, 9, 3, 5, 1, -1, -1);

    $display("[TB] start pulsed during FILL");
    pushWrite(6500, 51); pushWrite(6501, 51); pushWrite(7140, 51); pushWrite(7141, 51);
    applyStimulus(100, 10, 2, 2, 51, 6, -1, -1, 0, 3, -1);

    $display("[TB] reset mid-FILL");
    pushWrite(1280, 99); pushWrite(1281, 99);
    applyStimulus(0, 2, 3, 2, 99, 8, -1, -1, 0, -1, 4);

    $display("[TB] 1x1 after reset");
    pushWrite(645, 426);
    applyStimulus(5, 1, 1, 1, 426, 3, -1, -1, 0, -1, -1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
